// File: rtl/cpu_bus_responder.sv
// CPU bus responder for the 6502 core: decodes the NES CPU memory map, owns work RAM,
// forwards PPU register accesses, supplies PRG ROM data and runs the $4014 OAM DMA engine.
module cpu_bus_responder #(
  parameter int          RAM_AW  = 11,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  output logic [7:0]  cpu_din,
  output logic        cpu_rdy,
  output logic        ppu_sel,
  output logic [2:0]  ppu_reg,
  output logic        ppu_we,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic [14:0] prg_addr,
  input  logic [7:0]  prg_rdata,
  output logic        dma_active
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, RD, WR} state_t;

  state_t      state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q;
  logic [7:0]  count_q;
  logic [7:0]  latch_q;
  logic [7:0]  ram [2**RAM_AW];

  logic [15:0] act_addr;
  logic        is_ram, is_ppu, is_prg;
  logic        cpu_wr;
  logic        dma_start;
  logic [7:0]  rd_data;

  // Address decode on the active address: the CPU owns the bus only while IDLE
  always_comb begin
    act_addr  = (state_q == IDLE) ? cpu_addr : {page_q, count_q};
    is_ram    = (act_addr[15:13] == 3'b000);
    is_ppu    = (act_addr[15:13] == 3'b001);
    is_prg    = act_addr[15];
    cpu_wr    = (state_q == IDLE) && !cpu_r_nw;
    dma_start = cpu_wr && (cpu_addr == DMA_REG);
    prg_addr  = act_addr[14:0];
    if (is_ram)      rd_data = ram[act_addr[RAM_AW-1:0]];
    else if (is_ppu) rd_data = ppu_rdata;
    else if (is_prg) rd_data = prg_rdata;
    else             rd_data = cpu_din;
  end

  // PPU strobes are combinational in the access cycle; reset forces them quiet at once
  always_comb begin
    ppu_sel   = 1'b0;
    ppu_reg   = 3'd0;
    ppu_we    = 1'b0;
    ppu_wdata = 8'd0;
    if (rst) begin
      if (state_q == WR) begin
        ppu_sel   = 1'b1;
        ppu_reg   = 3'd4;
        ppu_we    = 1'b1;
        ppu_wdata = latch_q;
      end else if (((state_q == IDLE) || (state_q == RD)) && is_ppu) begin
        ppu_sel = 1'b1;
        ppu_reg = act_addr[2:0];
        ppu_we  = cpu_wr;
        if (cpu_wr) ppu_wdata = cpu_dout;
      end
    end
  end

  assign cpu_rdy    = (state_q == IDLE);
  assign dma_active = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dma_start) state_d = HALT;
      HALT:    state_d = parity_q ? RD : ALIGN;
      ALIGN:   state_d = RD;
      RD:      state_d = WR;
      WR:      state_d = (count_q == 8'hFF) ? IDLE : RD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      count_q  <= 8'd0;
      cpu_din  <= 8'd0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (dma_start)           count_q <= 8'd0;
      else if (state_q == WR)  count_q <= count_q + 8'd1;
      if ((state_q == IDLE) && cpu_r_nw) cpu_din <= rd_data;
    end
  end

  // Data-only registers: page, DMA latch and RAM are not cleared by reset
  always_ff @(posedge clk) begin
    if (dma_start)     page_q  <= cpu_dout;
    if (state_q == RD) latch_q <= rd_data;
    if (cpu_wr && is_ram) ram[act_addr[RAM_AW-1:0]] <= cpu_dout;
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: memory-map decode, PPU forwarding, open bus,
// OAM DMA timing on both cycle parities, and mid-transfer reset.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cpu_addr = 16'h5000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_r_nw = 1'b1;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        ppu_sel;
  logic [2:0]  ppu_reg;
  logic        ppu_we;
  logic [7:0]  ppu_wdata;
  logic [7:0]  ppu_rdata = 8'h00;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata = 8'h00;
  logic        dma_active;

  int vectors = 0;
  int miscompares = 0;
  int edges;

  cpu_bus_responder dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_r_nw(cpu_r_nw),
    .cpu_din(cpu_din), .cpu_rdy(cpu_rdy),
    .ppu_sel(ppu_sel), .ppu_reg(ppu_reg), .ppu_we(ppu_we), .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata), .prg_addr(prg_addr), .prg_rdata(prg_rdata),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Mirrors the DUT's cycle parity: value during a cycle = edges since reset release, mod 2
  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    cpu_addr = a;
    cpu_dout = d;
    cpu_r_nw = rnw;
  endtask

  task automatic test_reset();
    bus(16'h5000, 8'h00, 1'b1);
    #2;
    vectors++; if (cpu_din !== 8'h00) begin miscompares++; $display("FAIL reset_cpu_din: got %h expected 00", cpu_din); end
    vectors++; if (cpu_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_rdy: got %b expected 1", cpu_rdy); end
    vectors++; if (dma_active !== 1'b0) begin miscompares++; $display("FAIL reset_dma_active: got %b expected 0", dma_active); end
    vectors++; if ({ppu_sel, ppu_we, ppu_reg, ppu_wdata} !== 13'd0) begin miscompares++; $display("FAIL reset_ppu: got sel=%b we=%b reg=%0d wdata=%h expected all 0", ppu_sel, ppu_we, ppu_reg, ppu_wdata); end
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ram_mirror();
    bus(16'h0123, 8'hA5, 1'b0); tick();
    bus(16'h0923, 8'h00, 1'b1); tick();
    vectors++; if (cpu_din !== 8'hA5) begin miscompares++; $display("FAIL ram_mirror_0923: got %h expected a5", cpu_din); end
    bus(16'h1923, 8'h00, 1'b1); tick();
    vectors++; if (cpu_din !== 8'hA5) begin miscompares++; $display("FAIL ram_mirror_1923: got %h expected a5", cpu_din); end
    bus(16'h0000, 8'h33, 1'b0); tick();
    bus(16'h5000, 8'h00, 1'b1);
  endtask

  task automatic test_ppu();
    ppu_rdata = 8'h80;
    bus(16'h2002, 8'h00, 1'b1); #1;
    vectors++; if ({ppu_sel, ppu_reg, ppu_we} !== {1'b1, 3'd2, 1'b0}) begin miscompares++; $display("FAIL ppu_read_strobe: got sel=%b reg=%0d we=%b expected sel=1 reg=2 we=0", ppu_sel, ppu_reg, ppu_we); end
    tick();
    bus(16'h5000, 8'h00, 1'b1); ppu_rdata = 8'h00;
    vectors++; if (cpu_din !== 8'h80) begin miscompares++; $display("FAIL ppu_read_data: got %h expected 80", cpu_din); end
    bus(16'h3FFE, 8'h11, 1'b0); #1;
    vectors++; if ({ppu_sel, ppu_reg, ppu_we, ppu_wdata} !== {1'b1, 3'd6, 1'b1, 8'h11}) begin miscompares++; $display("FAIL ppu_write_strobe: got sel=%b reg=%0d we=%b wdata=%h expected sel=1 reg=6 we=1 wdata=11", ppu_sel, ppu_reg, ppu_we, ppu_wdata); end
    tick();
    bus(16'h5000, 8'h00, 1'b1);
  endtask

  task automatic test_prg_open_bus();
    prg_rdata = 8'h4C;
    bus(16'hC000, 8'h00, 1'b1); #1;
    vectors++; if (prg_addr !== 15'h4000) begin miscompares++; $display("FAIL prg_addr: got %h expected 4000", prg_addr); end
    tick();
    vectors++; if (cpu_din !== 8'h4C) begin miscompares++; $display("FAIL prg_read: got %h expected 4c", cpu_din); end
    bus(16'hC000, 8'h77, 1'b0); #1;
    vectors++; if (ppu_sel !== 1'b0) begin miscompares++; $display("FAIL prg_write_ppu: got sel=%b expected 0", ppu_sel); end
    tick();
    bus(16'h0000, 8'h00, 1'b1); tick();
    vectors++; if (cpu_din !== 8'h33) begin miscompares++; $display("FAIL prg_write_ram: got %h expected 33", cpu_din); end
    prg_rdata = 8'h5A;
    bus(16'h8000, 8'h00, 1'b1); tick();
    prg_rdata = 8'h00; ppu_rdata = 8'hEE;
    bus(16'h4016, 8'h00, 1'b1); tick();
    vectors++; if (cpu_din !== 8'h5A) begin miscompares++; $display("FAIL open_bus: got %h expected 5a", cpu_din); end
    ppu_rdata = 8'h00;
    bus(16'h5000, 8'h00, 1'b1);
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 256; i++) begin
      bus(16'h0200 + 16'(i), 8'(i), 1'b0);
      tick();
    end
    bus(16'h5000, 8'h00, 1'b1);
  endtask

  task automatic test_dma(input int want_odd);
    int stall = 0, strobes = 0, bad_order = 0, bad_par = 0, bad_act = 0;
    bit done = 0;
    prg_rdata = 8'h3C;
    bus(16'h8000, 8'h00, 1'b1); tick();
    bus(16'h5000, 8'h00, 1'b1);
    while ((edges % 2) != want_odd) tick();
    bus(16'h4014, 8'h02, 1'b0); tick();
    // CPU bus activity during the stall must be ignored
    prg_rdata = 8'h99;
    bus(16'h8000, 8'h00, 1'b1);
    for (int i = 0; i < 700 && !done; i++) begin
      if (cpu_rdy) done = 1;
      else begin
        stall++;
        if (dma_active !== 1'b1) bad_act++;
        if (ppu_sel && ppu_we) begin
          if (ppu_reg !== 3'd4 || ppu_wdata !== strobes[7:0]) bad_order++;
          if ((edges % 2) != 1) bad_par++;
          strobes++;
        end
        tick();
      end
    end
    vectors++; if (!done) begin miscompares++; $display("FAIL dma_timeout: got cpu_rdy=%b after 700 cycles expected 1", cpu_rdy); end
    vectors++; if (stall != (want_odd ? 514 : 513)) begin miscompares++; $display("FAIL dma_stall: got %0d expected %0d", stall, want_odd ? 514 : 513); end
    vectors++; if (strobes != 256) begin miscompares++; $display("FAIL dma_strobes: got %0d expected 256", strobes); end
    vectors++; if (bad_order != 0) begin miscompares++; $display("FAIL dma_order: got %0d bad writes expected 0", bad_order); end
    vectors++; if (bad_par != 0) begin miscompares++; $display("FAIL dma_parity: got %0d writes on even cycles expected 0", bad_par); end
    vectors++; if (bad_act != 0) begin miscompares++; $display("FAIL dma_active_during: got %0d low cycles expected 0", bad_act); end
    vectors++; if (dma_active !== 1'b0) begin miscompares++; $display("FAIL dma_active_after: got %b expected 0", dma_active); end
    vectors++; if (cpu_din !== 8'h3C) begin miscompares++; $display("FAIL dma_cpu_din_hold: got %h expected 3c", cpu_din); end
    prg_rdata = 8'h00;
    bus(16'h5000, 8'h00, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_dma();
    int strobes = 0;
    bit hit = 0;
    while ((edges % 2) != 0) tick();
    bus(16'h4014, 8'h02, 1'b0); tick();
    bus(16'h5000, 8'h00, 1'b1);
    for (int i = 0; i < 400 && !hit; i++) begin
      if (ppu_sel && ppu_we) begin
        if (strobes == 100) hit = 1;
        else strobes++;
      end
      if (!hit) tick();
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL mid_reset_reach: got %0d strobes expected pair 100", strobes); end
    #1 rst = 1'b0;
    #1;
    vectors++; if ({cpu_rdy, dma_active, ppu_sel, ppu_we} !== 4'b1000) begin miscompares++; $display("FAIL mid_reset_async: got rdy=%b act=%b sel=%b we=%b expected rdy=1 act=0 sel=0 we=0", cpu_rdy, dma_active, ppu_sel, ppu_we); end
    vectors++; if (cpu_din !== 8'h00) begin miscompares++; $display("FAIL mid_reset_cpu_din: got %h expected 00", cpu_din); end
    tick(); tick();
    rst = 1'b1;
    tick();
    bus(16'h0200, 8'h00, 1'b1); tick();
    vectors++; if (cpu_din !== 8'h00) begin miscompares++; $display("FAIL ram_kept_0200: got %h expected 00", cpu_din); end
    bus(16'h0263, 8'h00, 1'b1); tick();
    vectors++; if (cpu_din !== 8'h63) begin miscompares++; $display("FAIL ram_kept_0263: got %h expected 63", cpu_din); end
    bus(16'h5000, 8'h00, 1'b1);
    test_dma(0);
  endtask

  initial begin
    test_reset();
    test_ram_mirror();
    test_ppu();
    test_prg_open_bus();
    fill_ram();
    test_dma(0);
    test_dma(1);
    test_reset_mid_dma();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Bus-side responder for the 6502 core's address/data/R_nW interface; decodes every CPU cycle against the NES CPU memory map.
- Owns the 2 KB internal work RAM, forwards PPU register accesses, and supplies PRG ROM data.
- Implements the $4014 OAM DMA engine, which halts the CPU via cpu_rdy and drives 256 read/write pairs into PPU register 4.

Parameters:
- RAM_AW, 11, work RAM address width (2^RAM_AW bytes, mirrored across $0000-$1FFF).
- DMA_REG, 16'h4014, write address that launches OAM DMA.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- cpu_addr  input  16  CPU address bus
- cpu_dout  input  8  CPU write data
- cpu_r_nw  input  1  1 = read, 0 = write
- cpu_din  output  8  registered read data to CPU
- cpu_rdy  output  1  0 = CPU must freeze (DMA in progress)
- ppu_sel  output  1  PPU register access strobe, one cycle per access
- ppu_reg  output  3  PPU register index
- ppu_we  output  1  PPU write enable, qualified by ppu_sel
- ppu_wdata  output  8  PPU write data
- ppu_rdata  input  8  PPU read data, combinational, same cycle as ppu_sel
- prg_addr  output  15  PRG ROM address, combinational from the active address
- prg_rdata  input  8  PRG ROM data, combinational
- dma_active  output  1  high during every DMA cycle (HALT through final WR)

Behaviour:
- Reset (async, rst=0): cpu_din=0, cpu_rdy=1, dma_active=0, ppu_sel=0, ppu_we=0, ppu_wdata=0, ppu_reg=0, parity=0, FSM=IDLE. RAM contents are not cleared.
- Cycle parity: a flop that toggles every clk. Cycle 0 is the first edge after reset release.
- Decode, using the active address (CPU address when IDLE, DMA address otherwise):
  - $0000-$1FFF: RAM, index addr[RAM_AW-1:0].
  - $2000-$3FFF: PPU, ppu_reg=addr[2:0].
  - $8000-$FFFF: PRG ROM, prg_addr=addr[14:0]; writes ignored.
  - All other addresses: open bus. Reads return the current cpu_din; writes ignored, except DMA_REG.
- CPU read: data is sampled at the end of the access cycle and presented on cpu_din for the whole next cycle (1-cycle latency).
- CPU write: RAM commits at the end of the cycle. For the PPU, ppu_sel/ppu_we/ppu_wdata are asserted combinationally in the access cycle.
- FSM states: IDLE, HALT, ALIGN, RD, WR. Counter is 8 bits; the latch byte is 8 bits.
  - IDLE: a CPU write to DMA_REG in cycle n latches page=cpu_dout and count=0. Next state is HALT. cpu_rdy goes low from cycle n+1.
  - HALT (1 cycle): goes to RD if parity is odd, otherwise to ALIGN. RD always falls on even cycles.
  - ALIGN (1 cycle): goes to RD.
  - RD: reads {page,count} via the normal decode and latches the byte. If the source is in the PPU range, ppu_sel is asserted with ppu_we=0. Goes to WR.
  - WR: ppu_sel=1, ppu_reg=4, ppu_we=1, ppu_wdata=latch, count++. If count was 255, goes to IDLE and cpu_rdy=1 from the next cycle; otherwise goes to RD.
- Stall length: 513 cycles for a write at an even cycle, 514 at an odd cycle.
- During DMA, CPU address, data and R_nW are ignored; cpu_din holds its value.
- Count wrap 255→0 ends the transfer. The page is not incremented.
- Mid-operation reset aborts DMA immediately with reset values. No partial-transfer state survives.

Test Plan:
1. Write $0123=A5, then read $0923 → cpu_din=A5 on the cycle after the read (mirroring); read $1923 → A5.
2. Read $2002 with ppu_rdata=80 → same cycle ppu_sel=1, ppu_reg=2, ppu_we=0; next cycle cpu_din=80. Write $3FFE=11 → ppu_reg=6, ppu_we=1, ppu_wdata=11.
3. Read $C000 with prg_rdata=4C → prg_addr=4000, cpu_din=4C. Write $C000 → no RAM or PPU effect. Read $4016 after a prior read of 5A → cpu_din=5A (open bus).
4. RAM $0200+i = i for i=0..255; write $4014=02 at an even cycle → cpu_rdy low exactly 513 cycles; 256 WR strobes with ppu_reg=4 and data 00..FF in order; dma_active low afterwards.
5. Same as scenario 4 with the write at an odd cycle → 514-cycle stall, one ALIGN cycle, RD only on even cycles.
6. Assert rst during pair 100 → cpu_rdy=1, dma_active=0, ppu_sel=0 without waiting for an edge. After release, read $0200 → 00 (RAM preserved); a new $4014 write restarts cleanly.
